// File: rtl/wavetable_fetch.sv
// Per-operator phase accumulator and two-point wavetable reader feeding the sample interpolator.
// Each accepted tick reads table[idx] and table[idx+1] from a synchronous ROM and presents them with the phase fraction.
module wavetable_fetch #(
  parameter int PHASE_W   = 32,
  parameter int ADDR_W    = 10,
  parameter int FRAC_W    = 20,
  parameter int MOD_SHIFT = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   En,
  input  logic                   phaseRst,
  input  logic [PHASE_W-1:0]     phaseInc,
  input  logic [15:0]            modIn,
  output logic [ADDR_W-1:0]      romAddr,
  input  logic [15:0]            romData,
  output logic [1:0][15:0]       samps,
  output logic [FRAC_W-1:0]      interp,
  output logic                   sampsValid,
  output logic                   busy
);

  localparam int DROP_W = PHASE_W - ADDR_W - FRAC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WT   = 2'd3
  } state_t;

  state_t              state_r;
  logic [PHASE_W-1:0]  acc_r;
  logic [FRAC_W-1:0]   frac_r;
  logic [15:0]         hold_r;

  logic [PHASE_W-1:0]  mod_off_s;
  logic [PHASE_W-1:0]  eff_phase_s;
  logic [ADDR_W-1:0]   idx_s;
  logic [FRAC_W-1:0]   frac_s;
  logic                unused_lsb_s;

  // Modulated phase for the current tick: modulation is sign-extended before the shift so negative FM wraps backwards.
  always_comb begin
    mod_off_s    = {{(PHASE_W-16){modIn[15]}}, modIn} << MOD_SHIFT;
    eff_phase_s  = acc_r + mod_off_s;
    idx_s        = eff_phase_s[PHASE_W-1 -: ADDR_W];
    frac_s       = eff_phase_s[PHASE_W-ADDR_W-1 -: FRAC_W];
    unused_lsb_s = ^eff_phase_s[DROP_W-1:0];
  end

  // Fetch sequencer, phase accumulator and registered interpolator outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      acc_r      <= {PHASE_W{1'b0}};
      frac_r     <= {FRAC_W{1'b0}};
      hold_r     <= 16'h0000;
      romAddr    <= {ADDR_W{1'b0}};
      samps      <= {2{16'h0000}};
      interp     <= {FRAC_W{1'b0}};
      sampsValid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sampsValid <= 1'b0;

      // Note-on clear wins over the accumulate; the fetch still uses the pre-clear phase.
      if (phaseRst) begin
        acc_r <= {PHASE_W{1'b0}};
      end else if ((state_r == IDLE) && En) begin
        acc_r <= acc_r + phaseInc;
      end

      case (state_r)
        IDLE: begin
          if (En) begin
            frac_r  <= frac_s;
            romAddr <= idx_s;
            busy    <= 1'b1;
            state_r <= RD0;
          end
        end
        RD0: begin
          romAddr <= romAddr + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_r <= RD1;
        end
        RD1: begin
          hold_r  <= romData;
          state_r <= WT;
        end
        WT: begin
          samps[1]   <= hold_r;
          samps[0]   <= romData;
          interp     <= frac_r;
          sampsValid <= 1'b1;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wavetable_fetch.sv
// Randomized self-checking bench for wavetable_fetch against a behavioural phase/ROM model.
module tb_wavetable_fetch;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             En;
  logic             phaseRst;
  logic [31:0]      phaseInc;
  logic [15:0]      modIn;
  logic [9:0]       romAddr;
  logic [15:0]      romData;
  logic [1:0][15:0] samps;
  logic [19:0]      interp;
  logic             sampsValid;
  logic             busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [15:0] rom [0:1023];
  logic [31:0] acc_m;
  logic [15:0] last_s1, last_s0;
  logic [19:0] last_fr;

  wavetable_fetch dut (
    .Clk(Clk), .Reset(Reset), .En(En), .phaseRst(phaseRst),
    .phaseInc(phaseInc), .modIn(modIn), .romAddr(romAddr), .romData(romData),
    .samps(samps), .interp(interp), .sampsValid(sampsValid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data for an address appears one cycle after it is presented
  always @(posedge Clk) romData <= rom[romAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_addr"}, romAddr, 32'd0);
    check({tag, "_s1"}, samps[1], 32'd0);
    check({tag, "_s0"}, samps[0], 32'd0);
    check({tag, "_interp"}, interp, 32'd0);
    check({tag, "_valid"}, sampsValid, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
  endtask

  // Reference: what one accepted tick should produce, from the phase rules alone
  task automatic predict(input logic [31:0] mod_ext_in, output logic [9:0] idx,
                         output logic [15:0] e1, output logic [15:0] e0, output logic [19:0] fr);
    logic [31:0] eff;
    logic [9:0]  nxt;
    eff = acc_m + (mod_ext_in << 16);
    idx = eff[31:22];
    fr  = eff[21:2];
    nxt = idx + 10'd1;
    e1  = rom[idx];
    e0  = rom[nxt];
  endtask

  task automatic do_fetch(input logic [31:0] inc, input logic [15:0] mod, input bit prst,
                          input bit mid_rst, input bit mid_en);
    logic [9:0]  idx, nxt;
    logic [15:0] e1, e0;
    logic [19:0] fr;
    predict({{16{mod[15]}}, mod}, idx, e1, e0, fr);
    nxt   = idx + 10'd1;
    acc_m = prst ? 32'd0 : acc_m + inc;
    phaseInc = inc; modIn = mod; phaseRst = prst; En = 1'b1;
    @(posedge Clk); #1;
    En = 1'b0; phaseRst = 1'b0; phaseInc = $urandom; modIn = 16'($urandom);
    @(negedge Clk);
    check("addr_idx", romAddr, idx);
    check("busy_rd0", busy, 32'd1);
    check("valid_rd0", sampsValid, 32'd0);
    if (mid_en) En = 1'b1;
    if (mid_rst) phaseRst = 1'b1;
    @(negedge Clk);
    check("addr_idx1", romAddr, nxt);
    En = 1'b0; phaseRst = 1'b0;
    if (mid_rst) acc_m = 32'd0;
    @(negedge Clk);
    check("valid_wt", sampsValid, 32'd0);
    @(negedge Clk);
    check("valid_pulse", sampsValid, 32'd1);
    check("samps1", samps[1], e1);
    check("samps0", samps[0], e0);
    check("interp", interp, fr);
    check("busy_done", busy, 32'd0);
    last_s1 = e1; last_s0 = e0; last_fr = fr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check("idle_valid", sampsValid, 32'd0);
      check("idle_hold1", samps[1], last_s1);
      check("idle_hold0", samps[0], last_s0);
      check("idle_holdf", interp, last_fr);
    end
  endtask

  task automatic clear_phase();
    phaseRst = 1'b1;
    @(posedge Clk); #1;
    phaseRst = 1'b0;
    acc_m = 32'd0;
    @(negedge Clk);
  endtask

  initial begin
    logic [9:0]  i_idx;
    logic [15:0] x1 [3], x0 [3];
    logic [19:0] xf [3];
    int pulses, lows;

    Reset = 1'b0; En = 1'b0; phaseRst = 1'b0; phaseInc = 32'd0; modIn = 16'd0;
    for (int i = 0; i < 1024; i++) rom[i] = 16'(4 * i);
    acc_m = 32'd0; last_s1 = 16'd0; last_s0 = 16'd0; last_fr = 20'd0;

    // Reset state, then quiet idle with En low
    repeat (3) @(negedge Clk);
    check_zero_outputs("rst");
    Reset = 1'b1;
    idle_cycles(4);
    check("idle_busy", busy, 32'd0);

    // Ramp table, directed fetches including back-to-back
    do_fetch(32'h0040_0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0040_0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    clear_phase();
    do_fetch(32'h0020_0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0020_0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Table wrap from 1023 to 0
    clear_phase();
    do_fetch(32'hFFC0_0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_fetch(32'hFFC0_0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Negative FM from zero phase, then confirm acc advanced by phaseInc only
    clear_phase();
    do_fetch(32'h0123_4567, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    check("fm_interp", interp, 32'h000F_C000);
    check("fm_s1", samps[1], 32'd4092);
    do_fetch(32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // En held high: one fetch accepted every 4 cycles
    clear_phase();
    for (int j = 0; j < 3; j++) begin
      predict(32'd0, i_idx, x1[j], x0[j], xf[j]);
      acc_m = acc_m + 32'h0031_0000;
    end
    phaseInc = 32'h0031_0000; modIn = 16'd0; En = 1'b1;
    pulses = 0; lows = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k == 12) En = 1'b0;
      if (sampsValid) pulses++;
      if (!busy) lows++;
      check("hold_valid", sampsValid, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) begin
        check("hold_s1", samps[1], x1[k/4-1]);
        check("hold_s0", samps[0], x0[k/4-1]);
        check("hold_interp", interp, xf[k/4-1]);
      end
    end
    check("hold_pulses", pulses, 32'd3);
    check("hold_busy_low", lows, 32'd3);
    last_s1 = x1[2]; last_s0 = x0[2]; last_fr = xf[2];
    idle_cycles(2);

    // Reset asserted during RD1 aborts the fetch with no pulse
    phaseInc = 32'h0100_0000; modIn = 16'h0003; En = 1'b1;
    @(posedge Clk); #1; En = 1'b0;
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0; #1;
    check_zero_outputs("abort");
    @(negedge Clk); Reset = 1'b1;
    acc_m = 32'd0; last_s1 = 16'd0; last_s0 = 16'd0; last_fr = 20'd0;
    idle_cycles(6);

    // Randomized table and fetch traffic
    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    for (int n = 0; n < 60; n++) begin
      do_fetch($urandom, 16'($urandom), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
